// File: rtl/perf_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : perf_uart_pkg
// Purpose  : Shared types and helpers for the performance-counter UART reporter.
// Revision : 1.0 - initial release
// ============================================================================
package perf_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam logic [7:0] SYNC_BYTE        = 8'hA5;
    localparam int         FRAME_BYTES_BASE = 13;

    typedef struct packed {
        logic [31:0] total;
        logic [31:0] stall;
        logic [31:0] flush;
    } perf_snap_t;

    // Byte 0 is the sync marker; bytes 1..12 walk the snapshot MSB byte first.
    function automatic logic [7:0] frame_byte(input perf_snap_t snap, input logic [3:0] idx);
        logic [95:0] flat;
        logic [7:0]  b;
        flat = snap;
        b    = SYNC_BYTE;
        for (int k = 1; k <= 12; k++) begin
            if (idx == 4'(k)) begin
                b = flat[8*(13-k)-1 -: 8];
            end
        end
        return b;
    endfunction

endpackage : perf_uart_pkg
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_byte
// Purpose  : 8N1 byte serializer; a load on the final stop cycle chains the
//            next byte with no idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_byte
    import perf_uart_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    output logic       tx_o,
    output logic       done_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    tx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               bit_end;

    assign bit_end = (baud_q == CNT_W'(DIV - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_i) begin
                    state_d = START;
                    baud_d  = '0;
                    shift_d = byte_i;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                end else begin
                    baud_d  = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    done_o = 1'b1;
                    baud_d = '0;
                    if (load_i) begin
                        state_d = START;
                        shift_d = byte_i;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is registered from the next state so tx never glitches.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_o = tx_q;

endmodule : uart_tx_byte
`default_nettype wire

// File: rtl/perf_uart_reporter.sv
`default_nettype none
// ============================================================================
// Module   : perf_uart_reporter
// Purpose  : Snapshots the CPU perf counters on request and sends one framed
//            packet over UART. Define PERF_UART_CHECKSUM_EN to append an XOR
//            checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module perf_uart_reporter
    import perf_uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        report_req,
    input  logic [31:0] total_cycles,
    input  logic [31:0] stall_cycles,
    input  logic [31:0] flush_cycles,
    output logic        tx,
    output logic        busy,
    output logic        overrun,
    output logic [15:0] frames_sent
);

    localparam int DIV = CLK_HZ / BAUD;
`ifdef PERF_UART_CHECKSUM_EN
    localparam int N_BYTES = FRAME_BYTES_BASE + 1;
`else
    localparam int N_BYTES = FRAME_BYTES_BASE;
`endif

    perf_snap_t  snap_q;
    logic [3:0]  byte_idx_q;
    logic        busy_q;
    logic        overrun_q;
    logic [15:0] frames_q;

    logic        accept;
    logic        last_byte;
    logic [3:0]  next_idx;
    logic        tx_load;
    logic [7:0]  tx_byte;
    logic        tx_done;
    perf_snap_t  snap_in;

    assign snap_in   = '{total: total_cycles, stall: stall_cycles, flush: flush_cycles};
    assign accept    = report_req && !busy_q;
    assign last_byte = (byte_idx_q == 4'(N_BYTES - 1));
    assign next_idx  = byte_idx_q + 4'd1;
    assign tx_load   = accept || (tx_done && !last_byte);

`ifdef PERF_UART_CHECKSUM_EN
    logic [7:0] chk_q;

    function automatic logic [7:0] xor_bytes(input perf_snap_t s);
        logic [95:0] f;
        logic [7:0]  r;
        f = s;
        r = 8'h00;
        for (int k = 0; k < 12; k++) begin
            r = r ^ f[8*k +: 8];
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_q <= 8'h00;
        end else if (accept) begin
            chk_q <= xor_bytes(snap_in);
        end
    end

    always_comb begin
        tx_byte = SYNC_BYTE;
        if (!accept) begin
            if (next_idx == 4'(FRAME_BYTES_BASE)) begin
                tx_byte = chk_q;
            end else begin
                tx_byte = frame_byte(snap_q, next_idx);
            end
        end
    end
`else
    always_comb begin
        tx_byte = SYNC_BYTE;
        if (!accept) begin
            tx_byte = frame_byte(snap_q, next_idx);
        end
    end
`endif

    uart_tx_byte #(
        .DIV (DIV)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .load_i (tx_load),
        .byte_i (tx_byte),
        .tx_o   (tx),
        .done_o (tx_done)
    );

    // busy drops on the edge that ends the final stop bit, so a request in
    // that last cycle still counts as an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q     <= '0;
            byte_idx_q <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            frames_q   <= '0;
        end else begin
            if (accept) begin
                snap_q     <= snap_in;
                byte_idx_q <= '0;
                busy_q     <= 1'b1;
            end else if (tx_done) begin
                if (last_byte) begin
                    busy_q   <= 1'b0;
                    frames_q <= frames_q + 16'd1;
                end else begin
                    byte_idx_q <= next_idx;
                end
            end
            if (report_req && busy_q) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign frames_sent = frames_q;

endmodule : perf_uart_reporter
`default_nettype wire

// File: tb/tb_perf_uart_reporter.sv
`default_nettype none
// ============================================================================
// Module   : tb_perf_uart_reporter
// Purpose  : Scoreboard bench; a line monitor decodes tx and checks each byte
//            against the frame queued when the request was driven.
// Revision : 1.0 - initial release
// ============================================================================
module tb_perf_uart_reporter;

    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int DIV    = CLK_HZ / BAUD;
`ifdef PERF_UART_CHECKSUM_EN
    localparam int N_BYTES = 14;
`else
    localparam int N_BYTES = 13;
`endif
    localparam int FRAME_CYC = N_BYTES * 10 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        report_req = 1'b0;
    logic [31:0] total_cycles = '0;
    logic [31:0] stall_cycles = '0;
    logic [31:0] flush_cycles = '0;
    logic        tx;
    logic        busy;
    logic        overrun;
    logic [15:0] frames_sent;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];

    perf_uart_reporter #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .report_req   (report_req),
        .total_cycles (total_cycles),
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles),
        .tx           (tx),
        .busy         (busy),
        .overrun      (overrun),
        .frames_sent  (frames_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [31:0] t, input logic [31:0] s, input logic [31:0] f);
        logic [95:0] flat;
        logic [7:0]  b;
        logic [7:0]  chk;
        flat = {t, s, f};
        chk  = 8'h00;
        exp_q.push_back(8'hA5);
        for (int k = 0; k < 12; k++) begin
            b   = flat[95-8*k -: 8];
            chk = chk ^ b;
            exp_q.push_back(b);
        end
`ifdef PERF_UART_CHECKSUM_EN
        exp_q.push_back(chk);
`endif
    endtask

    // Line monitor: first sample is the first cycle of the start bit.
    task automatic decode_byte();
        logic [9:0] bits;
        logic       stable;
        stable = 1'b1;
        bits   = '0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < DIV; c++) begin
                if (!(b == 0 && c == 0)) @(negedge clk);
                if (rst) return;
                if (c == 0) bits[b] = tx;
                else if (tx !== bits[b]) stable = 1'b0;
            end
        end
        check("bit_width", 32'(stable), 32'd1);
        check("stop_bit", 32'(bits[9]), 32'd1);
        if (exp_q.size() == 0) begin
            check("unexpected_byte", 32'(bits[8:1]), 32'h100);
        end else begin
            check("byte", 32'(bits[8:1]), 32'(exp_q.pop_front()));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) decode_byte();
        end
    end

    // Drives one request and follows the frame; returns the number of busy
    // cycles. req_a/req_b inject extra requests on those busy cycles, rst_at
    // asserts reset on that busy cycle and returns early.
    task automatic run_frame(input logic [31:0] t, input logic [31:0] s, input logic [31:0] f,
                             input int req_a, input int req_b, input int rst_at,
                             input bit scramble, output int cnt);
        int guard;
        @(negedge clk);
        total_cycles = t;
        stall_cycles = s;
        flush_cycles = f;
        report_req   = 1'b1;
        push_frame(t, s, f);
        cnt   = 0;
        guard = 0;
        forever begin
            @(negedge clk);
            guard++;
            if (!busy || guard > 3 * FRAME_CYC) break;
            cnt++;
            report_req = (cnt == req_a || cnt == req_b);
            if (scramble) begin
                total_cycles = $urandom();
                stall_cycles = $urandom();
                flush_cycles = $urandom();
            end
            if (rst_at != 0 && cnt == rst_at) begin
                report_req = 1'b0;
                rst = 1'b1;
                break;
            end
        end
        report_req = 1'b0;
    endtask

    initial begin
        int cyc;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle", {13'd0, tx, busy, overrun, frames_sent}, {13'd0, 1'b1, 1'b0, 1'b0, 16'd0});
        end

        run_frame(32'h01020304, 32'h0000000A, 32'hDEADBEEF, 0, 0, 0, 1'b0, cyc);
        check("busy_cycles", 32'(cyc), 32'(FRAME_CYC));
        repeat (2) @(negedge clk);
        check("tx_idle_after", 32'(tx), 32'd1);
        check("frames_1", 32'(frames_sent), 32'd1);
        check("queue_drained_1", 32'(exp_q.size()), 32'd0);

        run_frame(32'h11223344, 32'h55667788, 32'h99AABBCC, 0, 0, 0, 1'b1, cyc);
        check("busy_cycles_scr", 32'(cyc), 32'(FRAME_CYC));
        repeat (2) @(negedge clk);
        check("frames_2", 32'(frames_sent), 32'd2);
        check("overrun_clear", 32'(overrun), 32'd0);
        check("queue_drained_2", 32'(exp_q.size()), 32'd0);

        // Request on the final stop cycle must be refused.
        run_frame(32'hCAFEF00D, 32'h00000001, 32'h80000000, FRAME_CYC, 0, 0, 1'b0, cyc);
        check("busy_cycles_last", 32'(cyc), 32'(FRAME_CYC));
        repeat (50) @(negedge clk);
        check("overrun_last", 32'(overrun), 32'd1);
        check("no_second_frame", 32'(busy), 32'd0);
        check("frames_3", 32'(frames_sent), 32'd3);
        check("queue_drained_3", 32'(exp_q.size()), 32'd0);

        run_frame(32'h0BADBEEF, 32'hFFFFFFFF, 32'h00000000, FRAME_CYC / 2, 0, 0, 1'b0, cyc);
        check("busy_cycles_mid", 32'(cyc), 32'(FRAME_CYC));
        repeat (50) @(negedge clk);
        check("overrun_mid", 32'(overrun), 32'd1);
        check("frames_4", 32'(frames_sent), 32'd4);
        check("queue_drained_4", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of byte index 4.
        run_frame(32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 0, 0, 45 * DIV, 1'b0, cyc);
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frames", 32'(frames_sent), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_idle", 32'(tx), 32'd1);

        run_frame(32'h01020304, 32'h0000000A, 32'hDEADBEEF, 0, 0, 0, 1'b0, cyc);
        check("busy_cycles_post", 32'(cyc), 32'(FRAME_CYC));
        repeat (2) @(negedge clk);
        check("frames_post", 32'(frames_sent), 32'd1);
        check("queue_drained_post", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_perf_uart_reporter
`default_nettype wire
